// File: rtl/neuron_layer.sv
// neuron_layer: M parallel fixed-point MAC neurons over one shared D-sample input stream,
// with saturation and runtime ReLU; defining NEURON_LAYER_BIAS_EN adds a per-lane bias_in port.
module neuron_layer #(
    parameter int N = 16,
    parameter int Q = 8,
    parameter int D = 8,
    parameter int M = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           st,
    input  logic           relu_en,
    input  logic [N-1:0]   x_in,
    input  logic           x_valid,
    output logic           x_ready,
    input  logic [M*N-1:0] w_in,
`ifdef NEURON_LAYER_BIAS_EN
    input  logic [M*N-1:0] bias_in,
`endif
    output logic [M*N-1:0] y_out,
    output logic           y_valid,
    input  logic           y_ready,
    output logic           busy,
    output logic           done
);
    localparam int A  = 2*N - Q + $clog2(D) + 1;
    localparam int P  = A + Q;
    localparam int CW = D > 1 ? $clog2(D) : 1;
    localparam logic signed [A-1:0] MAXV = {{(A-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [A-1:0] MINV = {{(A-N+1){1'b1}}, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, ACT, OUT} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic relu_q;
    logic last;
    logic signed [A-1:0] acc [M];
    logic signed [A-1:0] init [M];
    logic signed [P-1:0] prod [M];
    logic [N-1:0] sat [M];
    logic [M*N-1:0] act;

    assign last    = cnt == CW'(D-1);
    assign x_ready = state == ACC;
    assign y_valid = state == OUT;
    assign busy    = state != IDLE;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = st ? ACC : IDLE;
            ACC:     state_nx = (x_valid && last) ? ACT : ACC;
            ACT:     state_nx = OUT;
            OUT:     state_nx = y_ready ? IDLE : OUT;
            default: state_nx = IDLE;
        endcase
    end

    // P-bit operands keep the full signed product; the floor shift happens before accumulation
    always_comb begin
        act = '0;
        for (int m = 0; m < M; m++) begin
            prod[m] = P'($signed(x_in)) * P'($signed(w_in[m*N +: N]));
`ifdef NEURON_LAYER_BIAS_EN
            init[m] = A'($signed(bias_in[m*N +: N]));
`else
            init[m] = '0;
`endif
            sat[m] = acc[m] > MAXV ? MAXV[N-1:0] : acc[m] < MINV ? MINV[N-1:0] : acc[m][N-1:0];
            act[m*N +: N] = (relu_q && sat[m][N-1]) ? '0 : sat[m];
        end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt    <= '0;
            relu_q <= 1'b0;
            y_out  <= '0;
            done   <= 1'b0;
            for (int m = 0; m < M; m++) acc[m] <= '0;
        end else begin
            done <= state == OUT && y_ready;
            if (state == IDLE && st) begin
                cnt    <= '0;
                relu_q <= relu_en;
                for (int m = 0; m < M; m++) acc[m] <= init[m];
            end
            if (x_ready && x_valid) begin
                cnt <= cnt + 1'b1;
                for (int m = 0; m < M; m++) acc[m] <= acc[m] + A'(prod[m] >>> Q);
            end
            if (state == ACT) y_out <= act;
        end
endmodule

// File: tb/tb_neuron_layer.sv
// tb_neuron_layer: scoreboard bench for neuron_layer at N=16 Q=8 D=4 M=2.
module tb_neuron_layer;
    localparam int N = 16, Q = 8, D = 4, M = 2;
    typedef logic [N-1:0]   xv_t [D];
    typedef logic [M*N-1:0] wv_t [D];

    logic clk = 0, rst = 1, st = 0, relu_en = 0, x_valid = 0, y_ready = 1;
    logic [N-1:0] x_in = '0;
    logic [M*N-1:0] w_in = '0, bias_in = '0;
    logic x_ready, y_valid, busy, done;
    logic [M*N-1:0] y_out;
    int n_vec = 0, n_err = 0;
    int cyc = 0, st_cyc = 0, yv_at = -1, done_at = -1;
    logic [M*N-1:0] sb [$];

    neuron_layer #(.N(N), .Q(Q), .D(D), .M(M)) dut (
        .clk(clk), .rst(rst), .st(st), .relu_en(relu_en),
        .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready), .w_in(w_in),
`ifdef NEURON_LAYER_BIAS_EN
        .bias_in(bias_in),
`endif
        .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [M*N-1:0] model(input bit relu, input xv_t xs, input wv_t ws, input logic [M*N-1:0] b);
        logic [M*N-1:0] r;
        longint a;
        r = '0;
        for (int m = 0; m < M; m++) begin
            a = longint'($signed(b[m*N +: N]));
            for (int i = 0; i < D; i++)
                a += (longint'($signed(xs[i])) * longint'($signed(ws[i][m*N +: N]))) >>> Q;
            if (a > 32767) a = 32767;
            else if (a < -32768) a = -32768;
            if (relu && a < 0) a = 0;
            r[m*N +: N] = a[N-1:0];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (y_valid && yv_at < 0) yv_at = cyc - st_cyc;
        if (done && done_at < 0) done_at = cyc - st_cyc;
        if (y_valid && y_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else chk("y_out", y_out, sb.pop_front());
        end
    end

    task automatic run_pass(input bit relu, input xv_t xs, input wv_t ws, input logic [M*N-1:0] b,
                            input int gap, input int hold, input bit chain, input logic [M*N-1:0] exp);
        int t;
        logic [M*N-1:0] cap;
        sb.push_back(exp);
        y_ready = (hold == 0);
        st = 1; relu_en = relu; bias_in = b; x_valid = 0;
        @(posedge clk); #1;
        st_cyc = cyc - 1; yv_at = -1; done_at = -1;
        st = 0; relu_en = ~relu; bias_in = '1;
        for (int i = 0; i < D; i++) begin
            if (i == 2 && gap > 0) begin
                x_valid = 0; x_in = '1; w_in = '1; st = 1;
                repeat (gap) begin
                    @(negedge clk); chk("x_ready_gap", x_ready, 1);
                    @(posedge clk); #1;
                end
                st = 0;
            end
            x_valid = 1; x_in = xs[i]; w_in = ws[i];
            t = 0;
            do begin @(negedge clk); t++; end while (!x_ready && t < 20);
            if (!x_ready) chk("x_ready_timeout", 0, 1);
            @(posedge clk); #1;
        end
        x_in = '1; w_in = '1;
        @(negedge clk); chk("x_ready_after", x_ready, 0);
        if (hold > 0) begin
            t = 0;
            do begin @(negedge clk); t++; end while (!y_valid && t < 20);
            cap = y_out;
            repeat (hold) begin
                chk("y_valid_hold", y_valid, 1);
                chk("y_out_stable", y_out, cap);
                @(negedge clk);
            end
            @(posedge clk); #1 y_ready = 1;
        end
        t = 0;
        while (!done && t < 20) begin @(negedge clk); t++; end
        chk("done", done, 1);
        x_valid = 0;
        if (!chain) begin
            @(negedge clk);
            chk("done_pulse", done, 0);
            chk("busy_idle", busy, 0);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        xv_t xs;
        wv_t ws;
        bit r;
        #2 rst = 0;
        #2;
        chk("rst_y_out", y_out, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_x_ready", x_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1;
        @(negedge clk);

        foreach (xs[i]) begin xs[i] = 16'h0100; ws[i] = {16'h0040, 16'h0080}; end
        run_pass(0, xs, ws, '0, 0, 0, 0, {16'h0100, 16'h0200});
        chk("lat_y_valid", yv_at, 6);
        chk("lat_done", done_at, 7);

        foreach (ws[i]) ws[i] = {16'h0100, 16'hFF00};
        run_pass(0, xs, ws, '0, 0, 0, 1, {16'h0400, 16'hFC00});
        run_pass(1, xs, ws, '0, 0, 0, 0, {16'h0400, 16'h0000});

        foreach (xs[i]) begin xs[i] = 16'h7FFF; ws[i] = {16'h7FFF, 16'h7FFF}; end
        run_pass(0, xs, ws, '0, 0, 0, 0, {16'h7FFF, 16'h7FFF});
        foreach (ws[i]) ws[i] = {16'h8000, 16'h8000};
        run_pass(0, xs, ws, '0, 0, 0, 0, {16'h8000, 16'h8000});

        foreach (xs[i]) begin xs[i] = 16'h0100; ws[i] = {16'h0040, 16'h0080}; end
        run_pass(0, xs, ws, '0, 3, 5, 0, {16'h0100, 16'h0200});

        st = 1; relu_en = 0;
        @(posedge clk); #1 st = 0;
        x_valid = 1; x_in = 16'h0100; w_in = {16'h0040, 16'h0080};
        @(posedge clk); @(posedge clk); #2 rst = 0; #1;
        chk("abort_y_out", y_out, 0);
        chk("abort_y_valid", y_valid, 0);
        chk("abort_x_ready", x_ready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        chk("abort_busy_held", busy, 0);
        x_valid = 0; #1 rst = 1;
        @(negedge clk);
        run_pass(0, xs, ws, '0, 0, 0, 0, {16'h0100, 16'h0200});

`ifdef NEURON_LAYER_BIAS_EN
        run_pass(0, xs, ws, {16'hFF00, 16'h0100}, 0, 0, 0, {16'h0000, 16'h0300});
`endif

        for (int k = 0; k < 4; k++) begin
            foreach (xs[i]) begin
                xs[i] = N'($urandom_range(0, 2047)) - 16'd1024;
                ws[i] = {N'($urandom_range(0, 2047)) - 16'd1024, N'($urandom_range(0, 2047)) - 16'd1024};
            end
            if (k == 3) foreach (xs[i]) begin xs[i] = N'($urandom); ws[i] = {N'($urandom), N'($urandom)}; end
            r = k[0];
            run_pass(r, xs, ws, '0, k, k, 0, model(r, xs, ws, '0));
        end

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
